// File: rtl/wb_pkg.sv
// Shared Wishbone definitions: cycle-type codes and the slave FSM states.
package wb_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_END     = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    ACK,
    BURST
  } wb_state_t;

endpackage

// File: rtl/wb_bram_spram.sv
// Single-port synchronous RAM with byte-lane writes and a registered read.
// No reset on purpose so the array maps onto block RAM.
module wb_bram_spram #(
  parameter int adr_width = 11
) (
  input  logic                 clk,
  input  logic [adr_width-1:0] addr,
  input  logic                 we,
  input  logic [3:0]           sel,
  input  logic [31:0]          din,
  output logic [31:0]          dout
);

  logic [31:0] mem [2**adr_width];

  // Byte-lane write and read-first registered read at the same address
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we && sel[i]) begin
        mem[addr][8*i +: 8] <= din[8*i +: 8];
      end
    end
    dout <= mem[addr];
  end

endmodule

// File: rtl/wb_bram.sv
// Wishbone slave around a byte-writable block RAM. Classic cycles take one
// wait state; linear incrementing bursts then stream one beat per cycle.
module wb_bram #(
  parameter int adr_width = 11
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic [2:0]  wb_cti_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  output logic        wb_ack_o
);

  import wb_pkg::*;

  localparam logic [adr_width-1:0] ONE = adr_width'(1);

  wb_state_t            state;
  logic [adr_width-1:0] ptr;
  logic [adr_width-1:0] cur_word;
  logic [adr_width-1:0] word_idx;
  logic [adr_width-1:0] ram_addr;
  logic                 ram_we;
  logic [31:0]          ram_q;
  logic                 req;
  logic                 unused_adr_bits;

  assign unused_adr_bits = ^{wb_adr_i[31:adr_width+2], wb_adr_i[1:0]};

  assign req      = wb_cyc_i & wb_stb_i;
  assign word_idx = wb_adr_i[adr_width+1:2];
  // ptr always points at the word after the one currently being served
  assign cur_word = ptr - ONE;
  assign wb_ack_o = (state != IDLE) & wb_cyc_i & wb_stb_i;
  assign wb_dat_o = ram_q;

  // RAM port steering: write beats target the current word, acked read beats
  // prefetch the next one, and a master wait holds the current word
  always_comb begin
    ram_addr = cur_word;
    ram_we   = 1'b0;
    case (state)
      IDLE: begin
        ram_addr = word_idx;
        ram_we   = req & wb_we_i;
      end
      BURST: begin
        if (wb_ack_o && !wb_we_i) begin
          ram_addr = ptr;
        end
        ram_we = wb_ack_o & wb_we_i;
      end
      default: begin
        ram_addr = cur_word;
        ram_we   = 1'b0;
      end
    endcase
  end

  // Cycle-control FSM and burst address counter
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state <= IDLE;
      ptr   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            ptr   <= word_idx + ONE;
            state <= (wb_cti_i == CTI_INCR) ? BURST : ACK;
          end
        end
        ACK: begin
          state <= IDLE;
        end
        BURST: begin
          if (!wb_cyc_i) begin
            state <= IDLE;
          end else if (wb_ack_o) begin
            ptr <= ptr + ONE;
            if (wb_cti_i != CTI_INCR) begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  wb_bram_spram #(
    .adr_width(adr_width)
  ) u_ram (
    .clk (sys_clk),
    .addr(ram_addr),
    .we  (ram_we),
    .sel (wb_sel_i),
    .din (wb_dat_i),
    .dout(ram_q)
  );

endmodule

// File: tb/tb_wb_bram.sv
// Bench for wb_bram: a default-size instance and a 16-word instance share the
// bus; a word-array memory model plus per-cycle ack/data expectations drive
// a compare process on every falling edge.
module tb_wb_bram;

  import wb_pkg::*;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic [31:0] wb_adr;
  logic [31:0] wb_dat_w;
  logic [2:0]  wb_cti;
  logic [3:0]  wb_sel;
  logic        wb_we;
  logic        wb_cyc;
  logic [1:0]  wb_stb;
  logic [31:0] dat0, dat1;
  logic        ack0, ack1;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 0;

  logic        exp_ack [2];
  logic [31:0] exp_dat [2];
  bit          exp_chk [2];

  logic [31:0] model0 [2048];
  logic [31:0] model1 [16];
  logic [31:0] got_q [$];
  logic [31:0] rd;

  always #5 sys_clk = ~sys_clk;

  wb_bram #(.adr_width(11)) dut0 (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .wb_adr_i(wb_adr),
    .wb_dat_i(wb_dat_w),
    .wb_dat_o(dat0),
    .wb_cti_i(wb_cti),
    .wb_sel_i(wb_sel),
    .wb_we_i (wb_we),
    .wb_cyc_i(wb_cyc),
    .wb_stb_i(wb_stb[0]),
    .wb_ack_o(ack0)
  );

  wb_bram #(.adr_width(4)) dut1 (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .wb_adr_i(wb_adr),
    .wb_dat_i(wb_dat_w),
    .wb_dat_o(dat1),
    .wb_cti_i(wb_cti),
    .wb_sel_i(wb_sel),
    .wb_we_i (wb_we),
    .wb_cyc_i(wb_cyc),
    .wb_stb_i(wb_stb[1]),
    .wb_ack_o(ack1)
  );

  function automatic logic [31:0] model_rd(input int d, input int w);
    return (d != 0) ? model1[w % 16] : model0[w % 2048];
  endfunction

  task automatic model_wr(input int d, input int w, input logic [31:0] v, input logic [3:0] s);
    logic [31:0] word;
    word = model_rd(d, w);
    for (int i = 0; i < 4; i++) begin
      if (s[i]) word[8*i +: 8] = v[8*i +: 8];
    end
    if (d != 0) model1[w % 16] = word;
    else        model0[w % 2048] = word;
  endtask

  task automatic set_exp(input int d, input logic a, input logic [31:0] q, input bit c);
    exp_ack[0] = 1'b0;
    exp_ack[1] = 1'b0;
    exp_chk[0] = 1'b0;
    exp_chk[1] = 1'b0;
    exp_ack[d] = a;
    exp_dat[d] = q;
    exp_chk[d] = c;
  endtask

  task automatic applyStimulus();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic bus_idle();
    wb_cyc = 1'b0;
    wb_stb = 2'b00;
    wb_we  = 1'b0;
    wb_cti = CTI_CLASSIC;
    wb_sel = 4'h0;
  endtask

  task automatic compare_dut(input int d, input logic a, input logic [31:0] q);
    vectors++;
    if (a !== exp_ack[d]) begin
      miscompares++;
      $display("[TB] FAIL ack_dut%0d at %0t: got %b expected %b", d, $time, a, exp_ack[d]);
    end
    if (exp_ack[d] && exp_chk[d]) begin
      vectors++;
      if (q !== exp_dat[d]) begin
        miscompares++;
        $display("[TB] FAIL data_dut%0d at %0t: got %h expected %h", d, $time, q, exp_dat[d]);
      end
    end
  endtask

  // Per-cycle comparison of both slaves against the current expectations
  always @(negedge sys_clk) begin
    if (chk_en) begin
      compare_dut(0, ack0, dat0);
      compare_dut(1, ack1, dat1);
    end
  end

  // Classic single cycle: request, one wait state, one ack, then bus idle
  task automatic classic(input int d, input int w, input bit wr, input logic [31:0] v,
                         input logic [3:0] s, output logic [31:0] q);
    wb_cyc    = 1'b1;
    wb_stb    = 2'b00;
    wb_stb[d] = 1'b1;
    wb_we     = wr;
    wb_adr    = 32'(w) << 2;
    wb_dat_w  = v;
    wb_sel    = s;
    wb_cti    = CTI_CLASSIC;
    set_exp(d, 1'b0, 32'h0, 1'b0);
    applyStimulus();
    set_exp(d, 1'b1, model_rd(d, w), !wr);
    #2 q = (d != 0) ? dat1 : dat0;
    applyStimulus();
    if (wr) model_wr(d, w, v, s);
    bus_idle();
    set_exp(d, 1'b0, 32'h0, 1'b0);
    applyStimulus();
  endtask

  // Linear burst with optional master wait, cyc abort or reset after stop_after beats
  task automatic run_burst(input int d, input int start, input int n, input bit wr,
                           input logic [31:0] wbase, input int wait_after, input int nwait,
                           input int stop_after, input bit use_rst);
    int depth;
    int w;
    depth = (d != 0) ? 16 : 2048;
    got_q.delete();
    wb_cyc    = 1'b1;
    wb_stb    = 2'b00;
    wb_stb[d] = 1'b1;
    wb_we     = wr;
    wb_adr    = 32'(start) << 2;
    wb_dat_w  = wbase;
    wb_sel    = 4'hF;
    wb_cti    = CTI_INCR;
    set_exp(d, 1'b0, 32'h0, 1'b0);
    applyStimulus();
    for (int b = 0; b < n; b++) begin
      w         = (start + b) % depth;
      wb_cti    = (b == n - 1) ? CTI_END : CTI_INCR;
      wb_dat_w  = wbase + 32'(b);
      wb_stb[d] = 1'b1;
      wb_cyc    = 1'b1;
      if (b == stop_after) begin
        if (use_rst) begin
          set_exp(d, 1'b0, 32'h0, 1'b0);
          #1 checkOutput("ack_before_rst", {31'b0, ack0}, 32'h1);
          #1 sys_rst = 1'b1;
          #1 checkOutput("ack_in_rst", {31'b0, ack0}, 32'h0);
          applyStimulus();
          sys_rst = 1'b0;
        end else begin
          wb_cyc = 1'b0;
          wb_stb = 2'b00;
          set_exp(d, 1'b0, 32'h0, 1'b0);
          applyStimulus();
        end
        bus_idle();
        set_exp(d, 1'b0, 32'h0, 1'b0);
        return;
      end
      set_exp(d, 1'b1, model_rd(d, w), !wr);
      #2 if (!wr) got_q.push_back((d != 0) ? dat1 : dat0);
      applyStimulus();
      if (wr) model_wr(d, w, wbase + 32'(b), 4'hF);
      if (b == wait_after) begin
        for (int k = 0; k < nwait; k++) begin
          wb_stb[d] = 1'b0;
          set_exp(d, 1'b0, 32'h0, 1'b0);
          applyStimulus();
        end
      end
    end
    bus_idle();
    set_exp(d, 1'b0, 32'h0, 1'b0);
    applyStimulus();
  endtask

  // Directed scenario sequence
  initial begin
    sys_rst  = 1'b1;
    bus_idle();
    wb_adr   = 32'h0;
    wb_dat_w = 32'h0;
    set_exp(0, 1'b0, 32'h0, 1'b0);
    #1 chk_en = 1'b1;
    repeat (2) @(posedge sys_clk);
    #1;
    checkOutput("reset_ack0", {31'b0, ack0}, 32'h0);
    checkOutput("reset_ack1", {31'b0, ack1}, 32'h0);
    sys_rst = 1'b0;
    applyStimulus();

    classic(0, 5, 1'b1, 32'hDEADBEEF, 4'hF, rd);
    classic(0, 5, 1'b0, 32'h0, 4'hF, rd);
    checkOutput("classic_rd_w5", rd, 32'hDEADBEEF);

    classic(0, 2, 1'b1, 32'h11223344, 4'hF, rd);
    classic(0, 2, 1'b1, 32'hAABBCCDD, 4'b0010, rd);
    classic(0, 2, 1'b0, 32'h0, 4'hF, rd);
    checkOutput("byte_lane_w2", rd, 32'h1122CC44);

    for (int i = 0; i < 4; i++) classic(0, 8 + i, 1'b1, 32'hA0 + 32'(i), 4'hF, rd);
    run_burst(0, 8, 4, 1'b0, 32'h0, -1, 0, -1, 1'b0);
    checkOutput("burst_len", 32'(got_q.size()), 32'd4);
    if (got_q.size() == 4) begin
      checkOutput("burst_b0", got_q[0], 32'hA0);
      checkOutput("burst_b3", got_q[3], 32'hA3);
    end

    run_burst(0, 8, 4, 1'b0, 32'h0, 1, 2, -1, 1'b0);
    checkOutput("wait_len", 32'(got_q.size()), 32'd4);
    if (got_q.size() == 4) begin
      checkOutput("wait_b2", got_q[2], 32'hA2);
      checkOutput("wait_b3", got_q[3], 32'hA3);
    end

    run_burst(0, 8, 4, 1'b0, 32'h0, -1, 0, 2, 1'b0);
    classic(0, 9, 1'b0, 32'h0, 4'hF, rd);
    checkOutput("after_abort_w9", rd, 32'hA1);

    run_burst(0, 8, 4, 1'b0, 32'h0, -1, 0, 2, 1'b1);
    classic(0, 10, 1'b0, 32'h0, 4'hF, rd);
    checkOutput("after_rst_w10", rd, 32'hA2);

    classic(1, 14, 1'b1, 32'hE, 4'hF, rd);
    classic(1, 15, 1'b1, 32'hF, 4'hF, rd);
    classic(1, 0, 1'b1, 32'h0, 4'hF, rd);
    classic(1, 1, 1'b1, 32'h1, 4'hF, rd);
    run_burst(1, 15, 3, 1'b0, 32'h0, -1, 0, -1, 1'b0);
    checkOutput("wrap_len", 32'(got_q.size()), 32'd3);
    if (got_q.size() == 3) begin
      checkOutput("wrap_b0", got_q[0], 32'hF);
      checkOutput("wrap_b1", got_q[1], 32'h0);
      checkOutput("wrap_b2", got_q[2], 32'h1);
    end
    run_burst(1, 15, 3, 1'b1, 32'h100, -1, 0, -1, 1'b0);
    run_burst(1, 15, 3, 1'b0, 32'h0, -1, 0, -1, 1'b0);
    if (got_q.size() == 3) begin
      checkOutput("wrap_wr_b0", got_q[0], 32'h100);
      checkOutput("wrap_wr_b2", got_q[2], 32'h102);
    end
    classic(1, 14, 1'b0, 32'h0, 4'hF, rd);
    checkOutput("wrap_w14_kept", rd, 32'hE);

    run_burst(0, 20, 3, 1'b1, 32'h500, 0, 1, -1, 1'b0);
    run_burst(0, 20, 3, 1'b0, 32'h0, -1, 0, -1, 1'b0);
    if (got_q.size() == 3) checkOutput("wr_burst_b1", got_q[1], 32'h501);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
